// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - I2C target write receiver: START/STOP detect, byte deserialise, ACK/NACK drive
module i2c_target_rx #(
    parameter logic [6:0] OWN_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       ack_en,
    output logic       sda_oe,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_is_addr,
    output logic       addr_match,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_ACK = 3'd4,
        S_IGNORE   = 3'd5
    } state_t;

    // synchroniser and history flops; idle bus level is high
    logic r_scl_m, r_scl_s, r_scl_d;
    logic r_sda_m, r_sda_s, r_sda_d;

    state_t     r_state;
    logic [7:0] r_shreg;
    logic [2:0] r_bitcnt;
    logic       r_got8;
    logic       r_matched;
    logic       r_acked;
    logic       r_sda_oe;
    logic [7:0] r_byte_data;
    logic       r_byte_valid;
    logic       r_byte_is_addr;
    logic       r_addr_match;
    logic       r_busy;
    logic       r_start_det;
    logic       r_stop_det;

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_next_byte;
    logic       w_match;

    // bring both bus lines into the clk domain and keep one cycle of history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_m <= 1'b1;
            r_scl_s <= 1'b1;
            r_scl_d <= 1'b1;
            r_sda_m <= 1'b1;
            r_sda_s <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_m <= scl_in;
            r_scl_s <= r_scl_m;
            r_scl_d <= r_scl_s;
            r_sda_m <= sda_in;
            r_sda_s <= r_sda_m;
            r_sda_d <= r_sda_s;
        end
    end

    // START/STOP require SCL stable high, so they never coincide with an SCL edge
    assign w_scl_rise  = r_scl_s & ~r_scl_d;
    assign w_scl_fall  = ~r_scl_s & r_scl_d;
    assign w_start     = r_scl_s & r_scl_d & r_sda_d & ~r_sda_s;
    assign w_stop      = r_scl_s & r_scl_d & ~r_sda_d & r_sda_s;

    // byte as it will look after the current rise; write-only address match
    assign w_next_byte = {r_shreg[6:0], r_sda_s};
    assign w_match     = (r_shreg[6:0] == OWN_ADDR) && !r_sda_s;

    // protocol FSM: bus conditions first, then per-state bit/ack handling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_shreg        <= 8'h00;
            r_bitcnt       <= 3'd0;
            r_got8         <= 1'b0;
            r_matched      <= 1'b0;
            r_acked        <= 1'b0;
            r_sda_oe       <= 1'b0;
            r_byte_data    <= 8'h00;
            r_byte_valid   <= 1'b0;
            r_byte_is_addr <= 1'b0;
            r_addr_match   <= 1'b0;
            r_busy         <= 1'b0;
            r_start_det    <= 1'b0;
            r_stop_det     <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_start_det  <= 1'b0;
            r_stop_det   <= 1'b0;
            if (w_start) begin
                r_state     <= S_ADDR;
                r_shreg     <= 8'h00;
                r_bitcnt    <= 3'd0;
                r_got8      <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_start_det <= 1'b1;
                r_busy      <= 1'b1;
            end else if (w_stop) begin
                r_state    <= S_IDLE;
                r_shreg    <= 8'h00;
                r_bitcnt   <= 3'd0;
                r_got8     <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_stop_det <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_DATA: begin
                        if (w_scl_rise && !r_got8) begin
                            r_shreg  <= w_next_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                // byte complete; the ack slot starts at the next SCL fall
                                r_got8         <= 1'b1;
                                r_byte_data    <= w_next_byte;
                                r_byte_valid   <= 1'b1;
                                r_byte_is_addr <= (r_state == S_ADDR);
                                r_addr_match   <= (r_state == S_ADDR) && w_match;
                                if (r_state == S_ADDR) begin
                                    r_matched <= w_match;
                                end
                            end
                        end else if (w_scl_fall && r_got8) begin
                            r_got8 <= 1'b0;
                            if (r_state == S_ADDR) begin
                                r_state  <= S_ADDR_ACK;
                                r_sda_oe <= r_matched;
                            end else begin
                                // ack_en only matters in this one cycle
                                r_state  <= S_DATA_ACK;
                                r_sda_oe <= ack_en;
                                r_acked  <= ack_en;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= r_matched ? S_DATA : S_IGNORE;
                        end
                    end
                    S_DATA_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= r_acked ? S_DATA : S_IGNORE;
                        end
                    end
                    default: begin
                        // IDLE and IGNORE wait for the next bus condition
                    end
                endcase
            end
        end
    end

    assign sda_oe       = r_sda_oe;
    assign byte_data    = r_byte_data;
    assign byte_valid   = r_byte_valid;
    assign byte_is_addr = r_byte_is_addr;
    assign addr_match   = r_addr_match;
    assign busy         = r_busy;
    assign start_det    = r_start_det;
    assign stop_det     = r_stop_det;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - randomized bus-master bench with transaction-level reference model
module tb_i2c_target_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       ack_en = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_is_addr;
    logic       addr_match;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    // open-drain wired-AND of master and target
    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx dut (
        .clk         (clk),
        .rst         (rst),
        .scl_in      (scl_m),
        .sda_in      (sda_line),
        .ack_en      (ack_en),
        .sda_oe      (sda_oe),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_is_addr(byte_is_addr),
        .addr_match  (addr_match),
        .busy        (busy),
        .start_det   (start_det),
        .stop_det    (stop_det)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: record reported bytes {is_addr, match, data} and event counts
    logic [9:0] mon_q[$];
    int n_start = 0;
    int n_stop  = 0;
    int n_oe    = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) mon_q.push_back({byte_is_addr, addr_match, byte_data});
            if (start_det) n_start <= n_start + 1;
            if (stop_det) n_stop <= n_stop + 1;
            if (sda_oe) n_oe <= n_oe + 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // reference model state
    bit [7:0]   td[$];
    bit         ta[$];
    logic [9:0] exp_q[$];
    bit         exp_ack[$];
    bit         obs_ack[$];
    int         rd_idx = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // expected reports and ACK line levels (0 = ACK) for one addressed segment
    task automatic model(input bit [7:0] a);
        bit m;
        bit live;
        m = (a[7:1] == 7'h50) && (a[0] == 1'b0);
        exp_q.push_back({1'b1, m, a});
        exp_ack.push_back(!m);
        live = m;
        foreach (td[i]) begin
            if (live) begin
                exp_q.push_back({1'b0, 1'b0, td[i]});
                exp_ack.push_back(!ta[i]);
                live = ta[i];
            end else begin
                exp_ack.push_back(1'b1);
            end
        end
    endtask

    task automatic send_bit(input bit b, output bit seen);
        sda_m = b;
        tick(4);
        scl_m = 1'b1;
        tick(3);
        seen = sda_line;
        tick(3);
        scl_m = 1'b0;
        tick(3);
    endtask

    task automatic send_byte(input bit [7:0] b, output bit ack);
        bit dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ack);
    endtask

    task automatic send_start;
        sda_m = 1'b1;
        tick(4);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b0;
        tick(6);
        scl_m = 1'b0;
        tick(3);
    endtask

    task automatic send_stop;
        sda_m = 1'b0;
        tick(4);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b1;
        tick(6);
    endtask

    task automatic drive(input bit [7:0] a);
        bit k;
        send_byte(a, k);
        obs_ack.push_back(k);
        foreach (td[i]) begin
            ack_en = ta[i];
            send_byte(td[i], k);
            obs_ack.push_back(k);
        end
        ack_en = 1'b1;
    endtask

    task automatic compare(input string tag);
        logic [9:0] o;
        logic [9:0] e;
        check({tag, "_nrep"}, mon_q.size() - rd_idx, exp_q.size());
        foreach (exp_q[i]) begin
            if (rd_idx + i < mon_q.size()) begin
                o = mon_q[rd_idx + i];
                e = exp_q[i];
                check({tag, "_data"}, o[7:0], e[7:0]);
                check({tag, "_isaddr"}, o[9], e[9]);
                if (e[9]) check({tag, "_match"}, o[8], e[8]);
            end
        end
        check({tag, "_nack"}, obs_ack.size(), exp_ack.size());
        foreach (exp_ack[i]) begin
            if (i < obs_ack.size()) check({tag, "_ackbit"}, obs_ack[i], exp_ack[i]);
        end
        rd_idx = mon_q.size();
        exp_q.delete();
        exp_ack.delete();
        obs_ack.delete();
    endtask

    task automatic txn(input bit [7:0] a, input string tag);
        int s0;
        int p0;
        int oe0;
        bit any_ack;
        s0  = n_start;
        p0  = n_stop;
        oe0 = n_oe;
        model(a);
        any_ack = 1'b0;
        foreach (exp_ack[i]) if (!exp_ack[i]) any_ack = 1'b1;
        send_start;
        check({tag, "_busy_on"}, busy, 1'b1);
        drive(a);
        send_stop;
        tick(8);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_nstart"}, n_start - s0, 1);
        check({tag, "_nstop"}, n_stop - p0, 1);
        if (!any_ack) check({tag, "_oe_never"}, n_oe - oe0, 0);
        compare(tag);
    endtask

    initial begin
        bit dummy;
        int s0;
        int p0;
        bit [7:0] a;
        int nd;

        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(2);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_is_addr", byte_is_addr, 1'b0);
        check("rst_addr_match", addr_match, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_start_det", start_det, 1'b0);
        check("rst_stop_det", stop_det, 1'b0);

        td = '{8'hA5};        ta = '{1'b1};        txn(8'hA0, "wr_a5");
        td = '{8'h3C};        ta = '{1'b1};        txn(8'hA2, "nomatch");
        td = '{8'h11, 8'h22}; ta = '{1'b0, 1'b1};  txn(8'hA0, "data_nack");
        td = '{8'h5A};        ta = '{1'b1};        txn(8'hA1, "read_addr");

        // repeated START after three data bits: partial byte must vanish
        s0 = n_start;
        p0 = n_stop;
        td.delete();
        ta.delete();
        model(8'hA0);
        send_start;
        drive(8'hA0);
        send_bit(1'b1, dummy);
        send_bit(1'b0, dummy);
        send_bit(1'b1, dummy);
        td = '{8'hC3};
        ta = '{1'b1};
        model(8'hA0);
        send_start;
        drive(8'hA0);
        send_stop;
        tick(8);
        check("rstart_nstart", n_start - s0, 2);
        check("rstart_nstop", n_stop - p0, 1);
        compare("rstart");

        // reset while the target holds ACK on the address byte
        send_start;
        for (int i = 7; i >= 0; i--) send_bit(a_const(i), dummy);
        sda_m = 1'b1;
        tick(4);
        scl_m = 1'b1;
        tick(3);
        check("midack_oe_before", sda_oe, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midack_oe_after", sda_oe, 1'b0);
        check("midack_busy_after", busy, 1'b0);
        rst = 1'b0;
        tick(6);
        rd_idx = mon_q.size();
        td = '{8'h77};
        ta = '{1'b1};
        txn(8'hA0, "post_rst");

        // randomized transactions
        for (int it = 0; it < 16; it++) begin
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hA0;
            nd = $urandom_range(0, 3);
            td.delete();
            ta.delete();
            for (int j = 0; j < nd; j++) begin
                td.push_back(8'($urandom));
                ta.push_back($urandom_range(0, 3) != 0);
            end
            txn(a, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic bit a_const(input int i);
        bit [7:0] v;
        v = 8'hA0;
        return v[i];
    endfunction

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

Bus-facing I2C target (slave) write receiver for the address translator. It samples raw SCL/SDA, detects START and STOP, and deserialises address and data bytes on SCL rising edges. It drives ACK/NACK on the 9th bit and presents each received byte to the translation core as a one-cycle valid pulse. It is the bus-side counterpart of the byte-level shift register that serialises translated bytes out toward downstream targets.

## Interface
- OWN_ADDR, 7'h50, 7-bit target address this block ACKs (write direction only)
- clk  input  1  system clock; must run at least 8x the SCL frequency
- rst  input  1  synchronous, active-high reset
- scl_in  input  1  raw SCL pin level, asynchronous
- sda_in  input  1  raw SDA pin level, asynchronous
- ack_en  input  1  core accepts data bytes; sampled at the SCL falling edge that ends bit 8 of a data byte
- sda_oe  output  1  1 = pull SDA low (open-drain enable); 0 = release
- byte_data  output  8  last received byte, MSB first on the wire
- byte_valid  output  1  one-cycle pulse; byte_data, byte_is_addr and addr_match are valid in this cycle
- byte_is_addr  output  1  the pulsed byte is the address byte (addr[6:0], rw)
- addr_match  output  1  address byte matched: byte[7:1]==OWN_ADDR and rw==0
- busy  output  1  high from START until STOP
- start_det  output  1  one-cycle pulse on START or repeated START
- stop_det  output  1  one-cycle pulse on STOP

## Operation
- Input conditioning: 2-flop synchroniser per line (scl_s, sda_s), plus one history register (scl_d, sda_d).
- scl_rise = scl_s & ~scl_d. scl_fall = ~scl_s & scl_d.
- START = scl_s & scl_d & sda_d & ~sda_s. STOP = scl_s & scl_d & ~sda_d & sda_s.
- Events are mutually exclusive per cycle by construction. An SCL edge in the same cycle as an SDA change is treated as an SCL edge only.
- FSM states and transitions:
  - IDLE: goes to ADDR on START.
  - ADDR: shift sda_s into shreg on each scl_rise. bitcnt counts 0..7.
  - ADDR_ACK: entered on the scl_fall after the 8th rise. If matched, assert sda_oe. Leave on the next scl_fall (end of the 9th clock): go to DATA if matched, else IGNORE.
  - DATA: receive 8 bits as in ADDR.
  - DATA_ACK: assert sda_oe if ack_en was 1 at entry. On the 9th scl_fall, go to DATA if ACKed, else IGNORE.
  - IGNORE: no bytes reported; sda_oe stays 0. Leave only on START or STOP.
- Priority: START or STOP in any state overrides everything.
  - START: go to ADDR, clear bitcnt, release sda_oe, pulse start_det, set busy.
  - STOP: go to IDLE, release sda_oe, pulse stop_det, clear busy.
- rw=1 (read) addresses are NACKed even when the address bits match; the block then goes to IGNORE. Read service is outside this block.
- Reporting:
  - The address byte always reports byte_valid, with addr_match showing the result.
  - Data bytes report byte_valid only in DATA.
- Bit counter is 3 bits and wraps 7->0 on the 8th rise. A partial byte is discarded on START/STOP and never reported.
- Reset values: sda_oe=0, byte_data=0, byte_valid=0, byte_is_addr=0, addr_match=0, busy=0, start_det=0, stop_det=0. State=IDLE, shreg=0, bitcnt=0.
- Reset mid-transfer, including mid-ACK, releases sda_oe on the first clk edge with rst=1.

## Timing
- Pin to synchronised level: 2 clk. Pin edge to detected edge/condition: 3 clk.
- Detection in cycle N means:
  - shreg updates at the end of N;
  - start_det, stop_det and busy are registered high or low in N+1.
- 8th scl_rise detected in cycle N: byte_valid=1 in N+1 only. byte_data holds its value until the next byte_valid.
- sda_oe asserts in the cycle after the scl_fall that ends bit 8. It deasserts in the cycle after the 9th scl_fall. SDA is therefore stable across the 9th SCL high.
- ack_en is sampled in the scl_fall cycle that ends bit 8 and has no other effect.
- Minimum SCL high or low time: 4 clk.

## Test plan
- Reset, then START, address 0xA0 (0x50 write), data 0xA5, STOP:
  - byte_valid with byte_data=0xA0, byte_is_addr=1, addr_match=1;
  - sda_oe=1 during both 9th bits;
  - second byte_valid with byte_data=0xA5, byte_is_addr=0;
  - start_det/stop_det pulse once each; busy high in between.
- Address 0xA2 (0x51): byte_valid with addr_match=0; sda_oe never asserts. A following data byte 0x3C produces no byte_valid; STOP returns to IDLE.
- Matched address, data 0x11 with ack_en=0: byte_valid for 0x11; sda_oe stays 0 in the 9th bit. Next byte 0x22 is not reported.
- Address 0xA1 (read to 0x50): addr_match=0, NACK, IGNORE until STOP.
- Repeated START after 3 data bits, then address 0xA0: start_det pulses, the partial byte is never reported, the new address is ACKed.
- rst=1 while sda_oe=1 in an ACK slot: sda_oe=0, busy=0 on the next clk edge. The next transaction after reset is received normally.
